// File: rtl/sha_pkg.sv
// sha_pkg: shared constants and padder state encoding for the SHA-256 front end
package sha_pkg;
    localparam int BLOCK_W     = 512;
    localparam int LEN_FIELD_W = 64;
    localparam logic [7:0] PAD_BYTE = 8'h80;
    localparam int PTR_LEN_POS = 56;
    typedef enum logic [2:0] {ABSORB, PAD80, ZFILL, LEN, EMIT, DONE} pad_state_t;
endpackage

// File: rtl/sha_block_buf.sv
// sha_block_buf: 64-byte block register, byte 0 in the top bits
//   clk, reset    : clock and synchronous active-high reset (clears the block)
//   clr           : clear the whole block
//   we/addr/wdata : write one byte at index addr
//   len_we/len    : write the 64-bit length field into bytes 56..63
//   block         : current block contents
module sha_block_buf
    import sha_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   we,
    input  logic [5:0]             addr,
    input  logic [7:0]             wdata,
    input  logic                   len_we,
    input  logic [LEN_FIELD_W-1:0] len,
    output logic [BLOCK_W-1:0]     block
);
    always_ff @(posedge clk)
        if (reset || clr) block <= '0;
        else if (len_we) block[LEN_FIELD_W-1:0] <= len;
        else if (we) block[BLOCK_W-1-8*int'(addr) -: 8] <= wdata;
endmodule

// File: rtl/sha_padder.sv
// sha_padder: byte stream to padded 512-bit SHA-256 blocks
//   clk, reset                  : clock and synchronous active-high reset
//   data, data_valid, data_end  : message bytes and end-of-message strobe
//   delay                       : stall, inputs ignored while high
//   block, block_valid,
//   block_ready, block_last     : block handshake to the compression core
//   len_err                     : sticky length overflow (only with SHA_PADDER_OVF_CHECK_EN)
module sha_padder
    import sha_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data,
    input  logic               data_valid,
    input  logic               data_end,
    output logic               delay,
    output logic [BLOCK_W-1:0] block,
    output logic               block_valid,
    input  logic               block_ready,
    output logic               block_last
`ifdef SHA_PADDER_OVF_CHECK_EN
    ,
    output logic               len_err
`endif
);
    localparam logic [5:0] PTR_MAX  = 6'd63;
    localparam logic [5:0] FILL_END = 6'(PTR_LEN_POS - 1);
    pad_state_t state;
    logic [5:0] ptr;
    logic [LEN_W-1:0] bitlen;
    logic pad_done, last, we, len_we, clr, take;
    logic [7:0] wdata;
    assign take        = state == ABSORB && data_valid && !data_end;
    assign delay       = state != ABSORB;
    assign block_valid = state == EMIT;
    assign block_last  = block_valid && last;
    always_comb begin
        we     = take || state == PAD80 || state == ZFILL;
        wdata  = state == PAD80 ? PAD_BYTE : state == ZFILL ? 8'h00 : data;
        len_we = state == LEN;
        clr    = state == EMIT && block_ready;
    end
    sha_block_buf u_buf (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .we     (we),
        .addr   (ptr),
        .wdata  (wdata),
        .len_we (len_we),
        .len    (LEN_FIELD_W'(bitlen)),
        .block  (block)
    );
    // Filling stops one byte early (at 55) so LEN follows directly; ptr past 56
    // after the 0x80 never meets 55 and instead runs to 63, spilling into a new block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ABSORB;
            ptr      <= '0;
            bitlen   <= '0;
            pad_done <= 1'b0;
            last     <= 1'b0;
        end else begin
            case (state)
                ABSORB:
                    if (data_end) state <= PAD80;
                    else if (data_valid) begin
                        ptr    <= ptr + 6'd1;
                        bitlen <= bitlen + LEN_W'(8);
                        if (ptr == PTR_MAX) begin
                            state <= EMIT;
                            last  <= 1'b0;
                        end
                    end
                PAD80: begin
                    ptr      <= ptr + 6'd1;
                    pad_done <= 1'b1;
                    last     <= 1'b0;
                    state    <= ptr == PTR_MAX ? EMIT : ptr == FILL_END ? LEN : ZFILL;
                end
                ZFILL: begin
                    ptr   <= ptr + 6'd1;
                    state <= ptr == PTR_MAX ? EMIT : ptr == FILL_END ? LEN : ZFILL;
                end
                LEN: begin
                    state <= EMIT;
                    last  <= 1'b1;
                end
                EMIT:
                    if (block_ready) begin
                        ptr   <= '0;
                        state <= last ? DONE : pad_done ? ZFILL : ABSORB;
                    end
                DONE:
                    if (!data_end) begin
                        state    <= ABSORB;
                        bitlen   <= '0;
                        pad_done <= 1'b0;
                        last     <= 1'b0;
                    end
                default: state <= ABSORB;
            endcase
        end
    end
`ifdef SHA_PADDER_OVF_CHECK_EN
    // Adding 8 carries out exactly when every bit above bit 2 is already set.
    always_ff @(posedge clk)
        if (reset || (state == DONE && !data_end)) len_err <= 1'b0;
        else if (take && &bitlen[LEN_W-1:3]) len_err <= 1'b1;
`endif
endmodule
